// File: rtl/uart_term_decoder.sv
// uart_term_decoder
// Buffers bytes from the UART receiver in a small FIFO and interprets them as a
// minimal terminal stream. Printable characters, CR, LF, BS and a few ESC/CSI
// sequences are supported. The block issues character-cell writes to the text
// buffer, tracks the logical cursor, and drives the hardware scroll offset that
// the display scan-out uses.
module uart_term_decoder #(
  parameter int COLS       = 16,
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [$clog2(COLS)-1:0]   wr_x,
  output logic [$clog2(ROWS)-1:0]   wr_y,
  output logic [7:0]                wr_char,
  output logic [$clog2(COLS)-1:0]   cursor_x,
  output logic [$clog2(ROWS)-1:0]   cursor_y,
  output logic [$clog2(ROWS)-1:0]   scroll,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [XW-1:0] X_LAST    = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(ROWS - 1);
  localparam logic [AW:0]   FIFO_FULL = FIFO_DEPTH[AW:0];

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_SEMI  = 8'h3B;
  localparam logic [7:0] CH_LBRK  = 8'h5B;
  localparam logic [7:0] CH_LC_C  = 8'h63;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_J     = 8'h4A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WRITE,
    S_CLEAR,
    S_ESC,
    S_CSI
  } state_t;

  // ---------------------------------------------------------------------------
  // Input byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    rd_data_reg;
  logic          pop_en;
  logic          push_en;
  logic          drop;
  logic          fifo_nonempty;

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push_en       = rx_valid && ((count_reg != FIFO_FULL) || pop_en);
  assign drop          = rx_valid && !push_en;
  assign fifo_nonempty = (count_reg != '0);

  // Storage array with registered read; kept free of reset so it maps to RAM.
  // On a simultaneous push/pop at the same address the read returns the old
  // byte, which is exactly the byte being popped.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_mem[wr_ptr_reg] <= rx_data;
    end
    if (pop_en) begin
      rd_data_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  // FIFO pointers and occupancy; pointer widths make them wrap mod FIFO_DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder state
  // ---------------------------------------------------------------------------
  state_t        state_reg,    state_next;
  logic [XW-1:0] cursor_x_reg, cursor_x_next;
  logic [YW-1:0] cursor_y_reg, cursor_y_next;
  logic [YW-1:0] scroll_reg,   scroll_next;
  logic          wr_valid_reg, wr_valid_next;
  logic [XW-1:0] wr_x_reg,     wr_x_next;
  logic [YW-1:0] wr_y_reg,     wr_y_next;
  logic [7:0]    wr_char_reg,  wr_char_next;
  logic          clr_full_reg, clr_full_next;
  logic          byte_pend_reg, byte_pend_next;
  logic          overflow_reg, overflow_next;

  logic          lf_req;
  logic          full_clr;
  logic          is_printable;
  logic          is_csi_param;

  assign is_printable = (rd_data_reg >= 8'h20) && (rd_data_reg <= 8'h7E);
  assign is_csi_param = ((rd_data_reg >= 8'h30) && (rd_data_reg <= 8'h39)) ||
                        (rd_data_reg == CH_SEMI);

  // Decoder register bank; asynchronous reset abandons any write in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      cursor_x_reg  <= '0;
      cursor_y_reg  <= '0;
      scroll_reg    <= '0;
      wr_valid_reg  <= 1'b0;
      wr_x_reg      <= '0;
      wr_y_reg      <= '0;
      wr_char_reg   <= '0;
      clr_full_reg  <= 1'b0;
      byte_pend_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cursor_x_reg  <= cursor_x_next;
      cursor_y_reg  <= cursor_y_next;
      scroll_reg    <= scroll_next;
      wr_valid_reg  <= wr_valid_next;
      wr_x_reg      <= wr_x_next;
      wr_y_reg      <= wr_y_next;
      wr_char_reg   <= wr_char_next;
      clr_full_reg  <= clr_full_next;
      byte_pend_reg <= byte_pend_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Next-state, cursor/scroll update and write-command generation.
  always_comb begin
    state_next    = state_reg;
    cursor_x_next = cursor_x_reg;
    cursor_y_next = cursor_y_reg;
    scroll_next   = scroll_reg;
    wr_valid_next = wr_valid_reg;
    wr_x_next     = wr_x_reg;
    wr_y_next     = wr_y_reg;
    wr_char_next  = wr_char_reg;
    clr_full_next = clr_full_reg;
    pop_en        = 1'b0;
    lf_req        = 1'b0;
    full_clr      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop_en     = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        state_next = S_IDLE;
        if (is_printable) begin
          wr_valid_next = 1'b1;
          wr_x_next     = cursor_x_reg;
          wr_y_next     = cursor_y_reg + scroll_reg;
          wr_char_next  = rd_data_reg;
          state_next    = S_WRITE;
        end else begin
          case (rd_data_reg)
            CH_CR:  cursor_x_next = '0;
            CH_LF:  lf_req = 1'b1;
            CH_BS:  begin
              if (cursor_x_reg != '0) begin
                cursor_x_next = cursor_x_reg - 1'b1;
              end
            end
            CH_ESC: state_next = S_ESC;
            default: ;
          endcase
        end
      end

      S_WRITE: begin
        if (wr_ready) begin
          wr_valid_next = 1'b0;
          state_next    = S_IDLE;
          if (cursor_x_reg != X_LAST) begin
            cursor_x_next = cursor_x_reg + 1'b1;
          end else begin
            cursor_x_next = '0;
            lf_req        = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        if (wr_ready) begin
          if (wr_x_reg != X_LAST) begin
            wr_x_next = wr_x_reg + 1'b1;
          end else if (clr_full_reg && (wr_y_reg != Y_LAST)) begin
            wr_x_next = '0;
            wr_y_next = wr_y_reg + 1'b1;
          end else begin
            wr_valid_next = 1'b0;
            state_next    = S_IDLE;
          end
        end
      end

      // Fetch one byte, then interpret it on the following cycle.
      S_ESC: begin
        if (byte_pend_reg) begin
          state_next = S_IDLE;
          if (rd_data_reg == CH_LBRK) begin
            state_next = S_CSI;
          end else if (rd_data_reg == CH_LC_C) begin
            full_clr = 1'b1;
          end
        end else if (fifo_nonempty) begin
          pop_en = 1'b1;
        end
      end

      S_CSI: begin
        if (byte_pend_reg) begin
          state_next = S_IDLE;
          if (is_csi_param) begin
            state_next = S_CSI;
          end else if (rd_data_reg == CH_H) begin
            cursor_x_next = '0;
            cursor_y_next = '0;
          end else if (rd_data_reg == CH_J) begin
            full_clr = 1'b1;
          end
        end else if (fifo_nonempty) begin
          pop_en = 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Line feed: move down, or at the bottom scroll the view by one row and
    // blank the row that just became the bottom one. That physical row is
    // the one that was at the top before the scroll, i.e. the old offset.
    if (lf_req) begin
      if (cursor_y_reg != Y_LAST) begin
        cursor_y_next = cursor_y_reg + 1'b1;
        state_next    = S_IDLE;
      end else begin
        scroll_next   = scroll_reg + 1'b1;
        wr_valid_next = 1'b1;
        wr_x_next     = '0;
        wr_y_next     = scroll_reg;
        wr_char_next  = CH_SPACE;
        clr_full_next = 1'b0;
        state_next    = S_CLEAR;
      end
    end

    // Full clear restarts from a home cursor with no scroll, so physical and
    // logical rows coincide for the whole sweep.
    if (full_clr) begin
      scroll_next   = '0;
      cursor_x_next = '0;
      cursor_y_next = '0;
      wr_valid_next = 1'b1;
      wr_x_next     = '0;
      wr_y_next     = '0;
      wr_char_next  = CH_SPACE;
      clr_full_next = 1'b1;
      state_next    = S_CLEAR;
    end
  end

  // A byte popped from ESC/CSI is interpreted exactly one cycle later.
  always_comb begin
    byte_pend_next = pop_en;
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_next = drop | (overflow_reg & ~ovf_clr);
  end

  assign wr_valid = wr_valid_reg;
  assign wr_x     = wr_x_reg;
  assign wr_y     = wr_y_reg;
  assign wr_char  = wr_char_reg;
  assign cursor_x = cursor_x_reg;
  assign cursor_y = cursor_y_reg;
  assign scroll   = scroll_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_term_decoder.sv
// Testbench for uart_term_decoder: directed scenarios followed by randomized
// byte bursts. A terminal-level reference model predicts every cell write into
// a queue; an independent monitor pops and compares on each accepted write.
module tb_uart_term_decoder;

  localparam int COLS       = 16;
  localparam int ROWS       = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int XW         = $clog2(COLS);
  localparam int YW         = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [7:0]    wr_char;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic [YW-1:0] scroll;
  logic          overflow;
  logic          ovf_clr = 1'b0;

  uart_term_decoder #(
    .COLS(COLS),
    .ROWS(ROWS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_char(wr_char),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .scroll(scroll),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    c;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] burst_q[$];
  int         checks = 0;
  int         errors = 0;
  int         rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random

  // Reference terminal state
  int m_cx = 0;
  int m_cy = 0;
  int m_scroll = 0;
  int m_mode = 0;             // 0: text, 1: after ESC, 2: inside CSI

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void push_write(int x, int y, int c);
    wr_t w;
    w.x = XW'(x);
    w.y = YW'(y);
    w.c = 8'(c);
    exp_q.push_back(w);
  endfunction

  function automatic void model_clear_all();
    m_scroll = 0;
    m_cx = 0;
    m_cy = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_write(c, r, 32);
  endfunction

  function automatic void model_newline();
    if (m_cy < ROWS - 1) begin
      m_cy++;
    end else begin
      m_scroll = (m_scroll + 1) % ROWS;
      for (int c = 0; c < COLS; c++)
        push_write(c, (m_scroll + ROWS - 1) % ROWS, 32);
    end
  endfunction

  function automatic void model_byte(int b);
    if (m_mode == 1) begin
      m_mode = 0;
      if (b == 8'h5B) m_mode = 2;
      else if (b == 8'h63) model_clear_all();
    end else if (m_mode == 2) begin
      if (!((b >= 8'h30 && b <= 8'h39) || b == 8'h3B)) begin
        m_mode = 0;
        if (b == 8'h48) begin
          m_cx = 0;
          m_cy = 0;
        end else if (b == 8'h4A) begin
          model_clear_all();
        end
      end
    end else begin
      if (b >= 32 && b <= 126) begin
        push_write(m_cx, (m_cy + m_scroll) % ROWS, b);
        if (m_cx < COLS - 1) begin
          m_cx++;
        end else begin
          m_cx = 0;
          model_newline();
        end
      end else if (b == 13) begin
        m_cx = 0;
      end else if (b == 10) begin
        model_newline();
      end else if (b == 8) begin
        if (m_cx > 0) m_cx--;
      end else if (b == 27) begin
        m_mode = 1;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit accepted, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (accepted) model_byte(int'(b));
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_valid"}, int'(wr_valid), 0);
    check({tag, "_wr_x"},     int'(wr_x), 0);
    check({tag, "_wr_y"},     int'(wr_y), 0);
    check({tag, "_wr_char"},  int'(wr_char), 0);
    check({tag, "_cursor_x"}, int'(cursor_x), 0);
    check({tag, "_cursor_y"}, int'(cursor_y), 0);
    check({tag, "_scroll"},   int'(scroll), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // Wait for all predicted writes, let trailing control bytes settle, then
  // compare cursor/scroll state with the model.
  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (60) @(posedge clk);
    #1;
    check({tag, "_cursor_x"}, int'(cursor_x), m_cx);
    check({tag, "_cursor_y"}, int'(cursor_y), m_cy);
    check({tag, "_scroll"},   int'(scroll), m_scroll);
    check({tag, "_wr_valid_idle"}, int'(wr_valid), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  function automatic void gen_burst(int target);
    int r;
    int r2;
    int np;
    burst_q.delete();
    while (burst_q.size() < target) begin
      r = $urandom_range(0, 99);
      if (r < 55)      burst_q.push_back(8'($urandom_range(32, 126)));
      else if (r < 62) burst_q.push_back(8'h0D);
      else if (r < 72) burst_q.push_back(8'h0A);
      else if (r < 78) burst_q.push_back(8'h08);
      else if (r < 84) burst_q.push_back(8'($urandom_range(0, 255)));
      else begin
        burst_q.push_back(8'h1B);
        r2 = $urandom_range(0, 9);
        if (r2 < 2)      burst_q.push_back(8'h63);
        else if (r2 < 3) burst_q.push_back(8'h78);
        else begin
          burst_q.push_back(8'h5B);
          np = $urandom_range(0, 2);
          for (int k = 0; k < np; k++)
            burst_q.push_back(($urandom_range(0, 3) == 0) ? 8'h3B : 8'(8'h30 + $urandom_range(0, 9)));
          r2 = $urandom_range(0, 9);
          if (r2 < 3)      burst_q.push_back(8'h4A);
          else if (r2 < 6) burst_q.push_back(8'h48);
          else             burst_q.push_back(8'h6D);
        end
      end
    end
    while (burst_q.size() > FIFO_DEPTH) void'(burst_q.pop_back());
  endfunction

  // ---------------------------------------------------------------------------
  // wr_ready driver
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'b0;
      default: wr_ready = ($urandom_range(0, 99) < 70);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard: one line per accepted cell write
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (resetn && wr_valid && wr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x=%0d y=%0d ch=%02h, expected no write",
                 wr_x, wr_y, wr_char);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wr_x, wr_y, wr_char} != mon_e) begin
          errors++;
          $display("FAIL write: got x=%0d y=%0d ch=%02h expected x=%0d y=%0d ch=%02h",
                   wr_x, wr_y, wr_char, mon_e.x, mon_e.y, mon_e.c);
        end else begin
          $display("write x=%0d y=%0d ch=%02h ok", wr_x, wr_y, wr_char);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int hi_cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // T1: single 'A', latency of three cycles from the strobe
    send_byte(8'h41, 1'b1, 0);
    @(posedge clk); #1;
    check("latency_early", int'(wr_valid), 0);
    @(posedge clk); #1;
    check("latency_3cyc", int'(wr_valid), 1);
    drain("t1");

    // T2: CR then COLS+1 'B' -> row wrap
    send_byte(8'h0D, 1'b1, 2);
    for (int i = 0; i < COLS + 1; i++) send_byte(8'h42, 1'b1, 2);
    drain("t2");

    // T3: move to bottom row, then LF scrolls and clears a row
    for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A, 1'b1, 2);
    drain("t3a");
    send_byte(8'h0A, 1'b1, 2);
    drain("t3b");

    // T4: stalled sink, FIFO overflow, stable outputs, ordered release.
    // One byte sits in the decoder, FIFO_DEPTH more are buffered, the rest drop.
    rdy_mode = 1;
    wr_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < FIFO_DEPTH + 4; i++)
      send_byte(8'(8'h61 + i), (i < FIFO_DEPTH + 1), 0);
    check("stall_wr_valid", int'(wr_valid), 1);
    for (int i = 0; i < 8; i++) begin
      check("stall_stable", int'({wr_x, wr_y, wr_char}), int'(exp_q[0]));
      @(posedge clk); #1;
    end
    check("overflow_set", int'(overflow), 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("overflow_cleared", int'(overflow), 0);
    rdy_mode = 0;
    wr_ready = 1'b1;
    drain("t4");

    // T5: ESC [ 2 J full clear, then a discarded ESC x and a normal 'Z'
    send_byte(8'h1B, 1'b1, 0);
    send_byte(8'h5B, 1'b1, 0);
    send_byte(8'h32, 1'b1, 0);
    send_byte(8'h4A, 1'b1, 0);
    drain("t5a");
    send_byte(8'h1B, 1'b1, 0);
    send_byte(8'h78, 1'b1, 0);
    send_byte(8'h5A, 1'b1, 0);
    drain("t5b");

    // T6: asynchronous reset in the middle of a full clear
    send_byte(8'h1B, 1'b1, 0);
    send_byte(8'h63, 1'b1, 20);
    check("clear_busy", int'(wr_valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    m_cx = 0;
    m_cy = 0;
    m_scroll = 0;
    m_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wr_valid) hi_cnt++;
    end
    check("post_reset_fifo_empty", hi_cnt, 0);
    send_byte(8'h51, 1'b1, 0);
    drain("t6");

    // Randomized bursts, each small enough to fit in the empty FIFO
    rdy_mode = 2;
    for (int bi = 0; bi < 40; bi++) begin
      gen_burst($urandom_range(4, FIFO_DEPTH));
      foreach (burst_q[k]) send_byte(burst_q[k], 1'b1, $urandom_range(0, 2));
      drain("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
